// File: rtl/surov_mem_if.sv
// surov_mem_if: core data-memory port plus console TX stream and exit status.
interface surov_mem_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] mem_addr, memwrite_data, memread_data, exit_code;
    logic [1:0] mem_size;
    logic [7:0] con_data;
    logic mem_rden, mem_wren, con_valid, con_ready, halt, fault;
    modport master(
        output mem_addr, mem_rden, mem_wren, mem_size, memwrite_data, con_ready,
        input memread_data, con_data, con_valid, halt, exit_code, fault
    );
    modport slave(
        input mem_addr, mem_rden, mem_wren, mem_size, memwrite_data, con_ready,
        output memread_data, con_data, con_valid, halt, exit_code, fault
    );
endinterface

// File: rtl/surov_mem_responder.sv
// surov_mem_responder: data-memory target with word RAM, console TX FIFO and exit register.
module surov_mem_responder #(
    parameter int XLEN = 32,
    parameter int MEM_WORDS = 4096,
    parameter int CON_DEPTH = 4,
    parameter logic [31:0] CON_ADDR = 32'hFFFF_FFF0,
    parameter logic [31:0] EXIT_ADDR = 32'hFFFF_FFF4
) (
    input logic clk,
    input logic rst,
    surov_mem_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(CON_DEPTH);
    localparam int PW = CW + 1;
    logic [XLEN-1:0] ram [MEM_WORDS];
    logic [7:0] fifo [CON_DEPTH];
    logic [PW-1:0] wp, rp, count;
    logic [1:0] lane, size;
    logic [AW-1:0] widx;
    logic [3:0] be;
    logic [XLEN-1:0] rword, rshift, rdata, wsh;
    logic is_con, is_exit, mmio, in_ram, misal, err, rd_ok, wr_ok;
    logic full, pop, push_req, push, drop, ram_we;
    assign lane = bus.mem_addr[1:0];
    assign size = bus.mem_size;
    assign widx = bus.mem_addr[AW+1:2];
    assign is_con = bus.mem_addr == CON_ADDR;
    assign is_exit = bus.mem_addr == EXIT_ADDR;
    assign mmio = is_con | is_exit;
    assign in_ram = bus.mem_addr[XLEN-1:AW+2] == '0;
    assign misal = (size == 2'd1 && lane[0]) || (size == 2'd2 && lane != 2'd0);
    // Both strobes high is an error on its own; otherwise only a real request can fault.
    assign err = (bus.mem_rden & bus.mem_wren) |
                 ((bus.mem_rden ^ bus.mem_wren) &
                  (size == 2'd3 | misal | ~(in_ram | mmio) | (mmio & size != 2'd2)));
    assign rd_ok = bus.mem_rden & ~err;
    assign wr_ok = bus.mem_wren & ~err;
    assign count = wp - rp;
    assign full = count == PW'(CON_DEPTH);
    assign pop = bus.con_valid & bus.con_ready;
    assign push_req = wr_ok & is_con & ~bus.halt;
    assign push = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;
    assign ram_we = wr_ok & in_ram & ~bus.halt;
    assign bus.con_valid = count != '0;
    assign bus.con_data = fifo[rp[CW-1:0]];
    assign rword = ram[widx];
    assign rshift = rword >> {lane, 3'b000};
    assign rdata = is_con ? XLEN'(PW'(CON_DEPTH) - count) :
                   is_exit ? bus.exit_code :
                   rshift & (size == 2'd0 ? XLEN'(8'hFF) : size == 2'd1 ? XLEN'(16'hFFFF) : '1);
    assign be = (size == 2'd0 ? 4'b0001 : size == 2'd1 ? 4'b0011 : 4'b1111) << lane;
    assign wsh = bus.memwrite_data << {lane, 3'b000};
    // RAM is never cleared, but a write coinciding with reset must not land.
    always_ff @(posedge clk or posedge rst)
        if (!rst && ram_we)
            for (int i = 0; i < 4; i++)
                if (be[i]) ram[widx][i*8 +: 8] <= wsh[i*8 +: 8];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.memread_data <= '0;
            bus.halt <= 1'b0;
            bus.exit_code <= '0;
            bus.fault <= 1'b0;
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < CON_DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (bus.mem_rden) bus.memread_data <= rd_ok ? rdata : '0;
            if (push) fifo[wp[CW-1:0]] <= bus.memwrite_data[7:0];
            wp <= wp + PW'(push);
            rp <= rp + PW'(pop);
            if (err | drop) bus.fault <= 1'b1;
            if (wr_ok & is_exit & ~bus.halt) begin
                bus.halt <= 1'b1;
                bus.exit_code <= bus.memwrite_data;
            end
        end
endmodule

// File: tb/tb_surov_mem_responder.sv
// tb_surov_mem_responder: directed vector tables plus hand-written FIFO, halt and reset sequences.
module tb_surov_mem_responder;
    localparam logic [31:0] CON = 32'hFFFF_FFF0;
    localparam logic [31:0] EXT = 32'hFFFF_FFF4;
    typedef struct {
        logic rd;
        logic wr;
        logic [1:0] sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic exp_f;
        string name;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0;
    int total = 0;
    vec_t tv[13];
    vec_t fv[10];
    surov_mem_if #(.XLEN(32)) bus ();
    surov_mem_responder dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic acc(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
        bus.mem_rden = rd;
        bus.mem_wren = wr;
        bus.mem_size = sz;
        bus.mem_addr = addr;
        bus.memwrite_data = wd;
        @(negedge clk);
        bus.mem_rden = 1'b0;
        bus.mem_wren = 1'b0;
    endtask
    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, " memread_data"}, bus.memread_data, 32'h0);
        chk({tag, " con_valid"}, 32'(bus.con_valid), 32'h0);
        chk({tag, " con_data"}, 32'(bus.con_data), 32'h0);
        chk({tag, " halt"}, 32'(bus.halt), 32'h0);
        chk({tag, " exit_code"}, bus.exit_code, 32'h0);
        chk({tag, " fault"}, 32'(bus.fault), 32'h0);
    endtask
    initial begin
        tv[0]  = '{1'b0, 1'b1, 2'd2, 32'h100, 32'h11223344, 32'h0, 1'b0, "sw 100"};
        tv[1]  = '{1'b1, 1'b0, 2'd0, 32'h101, 32'h0, 32'h33, 1'b0, "lb 101"};
        tv[2]  = '{1'b1, 1'b0, 2'd1, 32'h102, 32'h0, 32'h1122, 1'b0, "lh 102"};
        tv[3]  = '{1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 32'h11223344, 1'b0, "lw 100"};
        tv[4]  = '{1'b0, 1'b1, 2'd2, 32'h200, 32'h0, 32'h11223344, 1'b0, "sw 200"};
        tv[5]  = '{1'b0, 1'b1, 2'd0, 32'h203, 32'h000000AB, 32'h11223344, 1'b0, "sb 203"};
        tv[6]  = '{1'b1, 1'b0, 2'd2, 32'h200, 32'h0, 32'hAB000000, 1'b0, "lw 200"};
        tv[7]  = '{1'b0, 1'b1, 2'd1, 32'h206, 32'h1234BEEF, 32'hAB000000, 1'b0, "sh 206"};
        tv[8]  = '{1'b1, 1'b0, 2'd1, 32'h206, 32'h0, 32'h0000BEEF, 1'b0, "lh 206"};
        tv[9]  = '{1'b1, 1'b0, 2'd0, 32'h207, 32'h0, 32'h000000BE, 1'b0, "lb 207"};
        tv[10] = '{1'b1, 1'b0, 2'd1, 32'h201, 32'h0, 32'h0, 1'b1, "lh 201 misaligned"};
        tv[11] = '{1'b1, 1'b0, 2'd2, 32'h200, 32'h0, 32'hAB000000, 1'b1, "lw 200 after fault"};
        tv[12] = '{1'b0, 1'b0, 2'd2, 32'h200, 32'h0, 32'hAB000000, 1'b1, "idle hold"};
        fv[0] = '{1'b1, 1'b1, 2'd2, 32'h100, 32'h0, 32'h0, 1'b1, "rd and wr"};
        fv[1] = '{1'b1, 1'b0, 2'd3, 32'h100, 32'h0, 32'h0, 1'b1, "size 3"};
        fv[2] = '{1'b1, 1'b0, 2'd1, 32'h103, 32'h0, 32'h0, 1'b1, "half misaligned"};
        fv[3] = '{1'b0, 1'b1, 2'd2, 32'h102, 32'hDEADBEEF, 32'h0, 1'b1, "word misaligned"};
        fv[4] = '{1'b1, 1'b0, 2'd2, 32'h4000, 32'h0, 32'h0, 1'b1, "past RAM end"};
        fv[5] = '{1'b0, 1'b1, 2'd2, 32'h3FFC, 32'h5, 32'h0, 1'b0, "last RAM word"};
        fv[6] = '{1'b0, 1'b1, 2'd0, CON, 32'h41, 32'h0, 1'b1, "console byte"};
        fv[7] = '{1'b1, 1'b0, 2'd1, EXT, 32'h0, 32'h0, 1'b1, "exit half"};
        fv[8] = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b1, "unmapped"};
        fv[9] = '{1'b1, 1'b0, 2'd2, CON, 32'h0, 32'h0, 1'b0, "console word read"};
        bus.mem_rden = 1'b0;
        bus.mem_wren = 1'b0;
        bus.mem_size = 2'd0;
        bus.mem_addr = 32'h0;
        bus.memwrite_data = 32'h0;
        bus.con_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_zero("reset");
        for (int i = 0; i < 13; i++) begin
            acc(tv[i].rd, tv[i].wr, tv[i].sz, tv[i].addr, tv[i].wd);
            chk({tv[i].name, " data"}, bus.memread_data, tv[i].exp_rd);
            chk({tv[i].name, " fault"}, 32'(bus.fault), 32'(tv[i].exp_f));
        end
        for (int i = 0; i < 10; i++) begin
            do_reset;
            acc(fv[i].rd, fv[i].wr, fv[i].sz, fv[i].addr, fv[i].wd);
            chk({fv[i].name, " fault"}, 32'(bus.fault), 32'(fv[i].exp_f));
        end
        acc(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        chk("faulty write suppressed", bus.memread_data, 32'h11223344);
        do_reset;
        for (int i = 0; i < 5; i++) begin
            acc(1'b0, 1'b1, 2'd2, CON, 32'h41 + 32'(i));
            if (i == 0) begin
                chk("first push valid", 32'(bus.con_valid), 32'h1);
                chk("first push head", 32'(bus.con_data), 32'h41);
            end
            if (i == 3) chk("full no fault", 32'(bus.fault), 32'h0);
        end
        chk("overflow fault", 32'(bus.fault), 32'h1);
        acc(1'b1, 1'b0, 2'd2, CON, 32'h0);
        chk("free when full", bus.memread_data, 32'h0);
        bus.con_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain valid", 32'(bus.con_valid), 32'h1);
            chk("drain byte", 32'(bus.con_data), 32'h41 + 32'(i));
            @(negedge clk);
        end
        chk("drained empty", 32'(bus.con_valid), 32'h0);
        bus.con_ready = 1'b0;
        acc(1'b1, 1'b0, 2'd2, CON, 32'h0);
        chk("free when empty", bus.memread_data, 32'h4);
        do_reset;
        for (int i = 0; i < 4; i++) acc(1'b0, 1'b1, 2'd2, CON, 32'h50 + 32'(i));
        bus.con_ready = 1'b1;
        acc(1'b0, 1'b1, 2'd2, CON, 32'h5A);
        chk("push on full with pop fault", 32'(bus.fault), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("pop-push valid", 32'(bus.con_valid), 32'h1);
            chk("pop-push byte", 32'(bus.con_data), i < 3 ? 32'h51 + 32'(i) : 32'h5A);
            @(negedge clk);
        end
        chk("pop-push empty", 32'(bus.con_valid), 32'h0);
        bus.con_ready = 1'b0;
        do_reset;
        acc(1'b0, 1'b1, 2'd2, EXT, 32'd42);
        chk("exit halt", 32'(bus.halt), 32'h1);
        chk("exit code", bus.exit_code, 32'd42);
        chk("exit no fault", 32'(bus.fault), 32'h0);
        acc(1'b0, 1'b1, 2'd2, 32'h100, 32'h55);
        acc(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        chk("write after halt ignored", bus.memread_data, 32'h11223344);
        acc(1'b0, 1'b1, 2'd2, EXT, 32'd7);
        chk("second exit ignored", bus.exit_code, 32'd42);
        acc(1'b1, 1'b0, 2'd2, EXT, 32'h0);
        chk("exit read", bus.memread_data, 32'd42);
        acc(1'b0, 1'b1, 2'd2, CON, 32'h61);
        chk("console after halt", 32'(bus.con_valid), 32'h0);
        chk("halted writes no fault", 32'(bus.fault), 32'h0);
        do_reset;
        chk("reset clears halt", 32'(bus.halt), 32'h0);
        chk("reset clears exit", bus.exit_code, 32'h0);
        acc(1'b0, 1'b1, 2'd2, CON, 32'h58);
        acc(1'b0, 1'b1, 2'd2, CON, 32'h59);
        acc(1'b1, 1'b0, 2'd3, 32'h100, 32'h0);
        acc(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        chk("pre-reset fault", 32'(bus.fault), 32'h1);
        chk("pre-reset data", bus.memread_data, 32'h11223344);
        bus.con_ready = 1'b1;
        bus.mem_wren = 1'b1;
        bus.mem_size = 2'd2;
        bus.mem_addr = 32'h100;
        bus.memwrite_data = 32'hCAFEBABE;
        rst = 1'b1;
        #1;
        chk_zero("async reset");
        @(negedge clk);
        rst = 1'b0;
        bus.mem_wren = 1'b0;
        bus.con_ready = 1'b0;
        chk("fifo empty after reset", 32'(bus.con_valid), 32'h0);
        acc(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
        chk("write during reset dropped", bus.memread_data, 32'h11223344);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
